machine_timer: RTL and testbench
================================

# machine_timer

Memory-mapped RISC-V machine timer: a free-running 64-bit `mtime` counter and a 64-bit `mtimecmp` comparator, both reachable as 32-bit words over a simple single-cycle bus port. It sits directly upstream of the CSR file and drives its `mip.MTIP` input. Timer interrupts delivered to the trap logic originate here. Software reads and writes it through the core's load/store path.

## Interface
- `TICK_DIVIDER`, default 1: clock cycles per `mtime` increment; legal range ≥1.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `request`  in  1  bus access strobe, one cycle per access; the block is always ready.
- `write_enable`  in  1  qualifies `request` as a write.
- `address`  in  4  byte offset. Bits [3:2] select the word: 0 `mtime[31:0]`, 1 `mtime[63:32]`, 2 `mtimecmp[31:0]`, 3 `mtimecmp[63:32]`. Bits [1:0] are ignored.
- `write_value`  in  32  write data; full-word writes only.
- `read_value`  out  32  read data, valid while `response_valid` is high.
- `response_valid`  out  1  high the cycle after any `request` (read or write).
- `timer_interrupt`  out  1  registered MTIP level; feeds `mip.MTIP`.

## Operation
- Reset values:
  - `mtime` = 0.
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF (no interrupt out of reset).
  - Prescaler count = 0.
  - `timer_interrupt` = 0, `response_valid` = 0, `read_value` = 0.
- Prescaler:
  - Counts 0..`TICK_DIVIDER`-1 and asserts `tick` on the last value, then wraps to 0.
  - With `TICK_DIVIDER`=1, `tick` is high every cycle.
  - Writes to `mtime` do not disturb the prescaler.
- Counter:
  - On `tick`, `mtime` ← `mtime`+1, modulo 2^64.
  - 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Writes:
  - Take effect at the edge on which `request`&`write_enable` is sampled.
  - A write to either `mtime` half overrides the increment in that cycle. The written half takes `write_value`, the other half holds its value, and no carry crosses halves.
  - Counting resumes at the next `tick`.
- Reads:
  - Return the register value present before the sampling edge, i.e. the pre-write and pre-increment value.
  - `read_value` holds its last value when `response_valid` is low.
  - A write response returns the old word contents.
- Interrupt:
  - `timer_interrupt` ← (`mtime` ≥ `mtimecmp`), unsigned 64-bit compare, evaluated on current register values every cycle.
  - Level-sensitive. It clears only when software raises `mtimecmp` or writes `mtime` below it.
  - There is no acknowledge.
- Simultaneous events: a write to `mtimecmp` on the same edge that `mtime` crosses it is handled by using the new values in the next compare. There are no special cases.
- Reset asserted mid-operation: all state returns to reset values on that edge. A pending response is dropped (`response_valid`=0 next cycle).

## Timing
- Bus latency: exactly one cycle. `request` at edge N gives `response_valid`=1 and `read_value` after edge N, for one cycle.
- Back-to-back requests on consecutive cycles are fully supported.
- Interrupt latency:
  - If `mtime` reaches `mtimecmp` at edge N, `timer_interrupt` rises after edge N+1.
  - If a clearing write lands at edge N, the fall also happens after edge N+1.
- A read of `mtime` at edge N returns the count from before edge N.

## Structure
- Shared package holds:
  - The word offset constants `TIMER_MTIME_LO`/`HI` and `TIMER_MTIMECMP_LO`/`HI`.
  - `MTIMECMP_RESET` = all ones.
  - The 64-bit timer width constant.
- One sub-module, `tick_prescaler` (parameter `TICK_DIVIDER`; ports `clock`, `reset`, `tick`). When `TICK_DIVIDER`=1 it degenerates to a constant 1.
- The top level holds the counter, comparator, bus decode and response register.

## Test plan
- Reset, `TICK_DIVIDER`=1, idle 10 cycles, then read offset 0x0 → `read_value`=10; `timer_interrupt` stays 0 throughout.
- Write `mtimecmp` hi=0, lo=20 with `TICK_DIVIDER`=1 → `timer_interrupt` rises exactly one cycle after `mtime` reads 20. Then write `mtimecmp` lo=1000 → it falls two edges after the write.
- Write `mtime` hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFE; let 2 ticks elapse → `mtime` reads 0 in both halves, no X, and the compare against reset `mtimecmp` asserts and then deasserts at the wrap.
- `TICK_DIVIDER`=4: 12 cycles after reset → `mtime`=3. Write lo=100 mid-period → the next increment occurs on the unchanged prescaler schedule.
- Write offset 0x0 with value 5 on a tick cycle → the response shows the old value and the next read shows 5, not 6. Back-to-back read/write/read all respond in consecutive cycles.
- Assert `reset` the cycle after a read `request` → `response_valid`=0 and all reads afterwards match reset values.

Source files
------------

// File: rtl/machine_timer_pkg.sv
// Shared constants and types for the RISC-V machine timer: word offsets,
// timer width and the comparator reset value.
package machine_timer_pkg;

    localparam int TIMER_WIDTH = 64;

    typedef logic [TIMER_WIDTH-1:0] timer_t;

    // Word select taken from address[3:2].
    typedef enum logic [1:0] {
        TIMER_MTIME_LO    = 2'd0,
        TIMER_MTIME_HI    = 2'd1,
        TIMER_MTIMECMP_LO = 2'd2,
        TIMER_MTIMECMP_HI = 2'd3
    } timer_word_e;

    localparam timer_t MTIMECMP_RESET = '1;

    function automatic timer_word_e word_sel(input logic [1:0] word_bits);
        return timer_word_e'(word_bits);
    endfunction

endpackage

// File: rtl/machine_timer_if.sv
// Single-cycle bus port of the machine timer; the core's load/store path is
// the master, the timer is the slave.
interface machine_timer_if;
    logic        request;
    logic        write_enable;
    logic [3:0]  address;
    logic [31:0] write_value;
    logic [31:0] read_value;
    logic        response_valid;

    modport master (
        output request, write_enable, address, write_value,
        input  read_value, response_valid
    );

    modport slave (
        input  request, write_enable, address, write_value,
        output read_value, response_valid
    );
endinterface

// File: rtl/machine_timer_tick_prescaler.sv
// Divides the clock down to the mtime increment rate: tick is high on the
// last count of every TICK_DIVIDER-cycle period.
module tick_prescaler #(
    parameter int TICK_DIVIDER = 1
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    generate
        if (TICK_DIVIDER <= 1) begin : g_bypass
            // No state to keep; clock and reset are intentionally left unused.
            logic unused_inputs;
            assign unused_inputs = clock ^ reset;
            assign tick = 1'b1;
        end else begin : g_count
            localparam int CW = $clog2(TICK_DIVIDER);
            localparam logic [CW-1:0] LAST = CW'(TICK_DIVIDER - 1);

            logic [CW-1:0] count_q, count_d;

            always_comb begin
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    count_d = '0;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign tick = (count_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/machine_timer.sv
// RISC-V machine timer: free-running 64-bit mtime, 64-bit mtimecmp and a
// registered MTIP level, accessed as 32-bit words over a one-cycle bus.
module machine_timer
    import machine_timer_pkg::*;
#(
    parameter int TICK_DIVIDER = 1
) (
    input  logic              clock,
    input  logic              reset,
    machine_timer_if.slave    bus,
    output logic              timer_interrupt
);

    timer_t      mtime_q, mtime_d;
    timer_t      mtimecmp_q, mtimecmp_d;
    logic [31:0] read_value_q, read_value_d;
    logic        response_valid_q, response_valid_d;
    logic        timer_interrupt_q, timer_interrupt_d;

    logic        tick;
    logic        write_strobe;
    timer_word_e sel;
    logic [1:0]  unused_byte_lane;

    tick_prescaler #(
        .TICK_DIVIDER(TICK_DIVIDER)
    ) u_prescaler (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    assign sel              = word_sel(bus.address[3:2]);
    assign unused_byte_lane = bus.address[1:0];
    assign write_strobe     = bus.request & bus.write_enable;

    // NOTE: every signal gets a default at the top of always_comb so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        mtime_d           = tick ? mtime_q + timer_t'(1) : mtime_q;
        mtimecmp_d        = mtimecmp_q;
        read_value_d      = read_value_q;
        response_valid_d  = bus.request;
        timer_interrupt_d = (mtime_q >= mtimecmp_q);

        // Reads and write responses both return the pre-edge contents.
        if (bus.request) begin
            case (sel)
                TIMER_MTIME_LO:    read_value_d = mtime_q[31:0];
                TIMER_MTIME_HI:    read_value_d = mtime_q[63:32];
                TIMER_MTIMECMP_LO: read_value_d = mtimecmp_q[31:0];
                TIMER_MTIMECMP_HI: read_value_d = mtimecmp_q[63:32];
            endcase
        end

        // A write to either mtime half replaces the increment; no carry crosses halves.
        if (write_strobe) begin
            case (sel)
                TIMER_MTIME_LO:    mtime_d    = {mtime_q[63:32], bus.write_value};
                TIMER_MTIME_HI:    mtime_d    = {bus.write_value, mtime_q[31:0]};
                TIMER_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], bus.write_value};
                TIMER_MTIMECMP_HI: mtimecmp_d = {bus.write_value, mtimecmp_q[31:0]};
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            mtime_q           <= '0;
            mtimecmp_q        <= MTIMECMP_RESET;
            read_value_q      <= '0;
            response_valid_q  <= 1'b0;
            timer_interrupt_q <= 1'b0;
        end else begin
            mtime_q           <= mtime_d;
            mtimecmp_q        <= mtimecmp_d;
            read_value_q      <= read_value_d;
            response_valid_q  <= response_valid_d;
            timer_interrupt_q <= timer_interrupt_d;
        end
    end

    assign bus.read_value     = read_value_q;
    assign bus.response_valid = response_valid_q;
    assign timer_interrupt    = timer_interrupt_q;

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench: two timers (divider 1 and 4) share one bus stimulus and
// are compared every cycle against a behavioural 64-bit timer model.
module tb_machine_timer;

    logic        clock = 1'b0;
    logic        reset;
    logic        request;
    logic        write_enable;
    logic [3:0]  address;
    logic [31:0] write_value;
    logic        irq1, irq4;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state, index 0 = divider 1, index 1 = divider 4.
    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp   [2];
    logic [31:0] m_rd    [2];
    logic        m_rv    [2];
    logic        m_irq   [2];
    int          m_cyc   [2];

    always #5 clock = ~clock;

    machine_timer_if bus1();
    machine_timer_if bus4();

    assign bus1.request      = request;
    assign bus1.write_enable = write_enable;
    assign bus1.address      = address;
    assign bus1.write_value  = write_value;
    assign bus4.request      = request;
    assign bus4.write_enable = write_enable;
    assign bus4.address      = address;
    assign bus4.write_value  = write_value;

    machine_timer #(.TICK_DIVIDER(1)) dut1 (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus1),
        .timer_interrupt(irq1)
    );

    machine_timer #(.TICK_DIVIDER(4)) dut4 (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus4),
        .timer_interrupt(irq4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [63:0] t, input logic [63:0] c,
                                            input logic [1:0] w);
        case (w)
            2'd0:    return t[31:0];
            2'd1:    return t[63:32];
            2'd2:    return c[31:0];
            default: return c[63:32];
        endcase
    endfunction

    // One clock edge of the architectural timer, from the bus inputs just sampled.
    task automatic model(input int i);
        int          div;
        logic        tick;
        logic [63:0] t, c;
        div = (i == 0) ? 1 : 4;
        if (reset) begin
            m_mtime[i] = 64'd0;
            m_cmp[i]   = '1;
            m_rd[i]    = 32'd0;
            m_rv[i]    = 1'b0;
            m_irq[i]   = 1'b0;
            m_cyc[i]   = 0;
        end else begin
            t = m_mtime[i];
            c = m_cmp[i];
            m_irq[i] = (t >= c);
            m_rv[i]  = request;
            if (request) m_rd[i] = word_of(t, c, address[3:2]);
            tick = ((m_cyc[i] % div) == div - 1);
            m_cyc[i]++;
            if (tick) m_mtime[i] = t + 64'd1;
            if (request && write_enable) begin
                case (address[3:2])
                    2'd0:    m_mtime[i] = {t[63:32], write_value};
                    2'd1:    m_mtime[i] = {write_value, t[31:0]};
                    2'd2:    m_cmp[i]   = {c[63:32], write_value};
                    default: m_cmp[i]   = {write_value, c[31:0]};
                endcase
            end
        end
    endtask

    task automatic step(input logic rs, input logic rq, input logic we,
                        input logic [3:0] a, input logic [31:0] wd);
        reset        = rs;
        request      = rq;
        write_enable = we;
        address      = a;
        write_value  = wd;
        @(posedge clock);
        model(0);
        model(1);
        #1;
        check("rv_div1",  bus1.response_valid, 64'(m_rv[0]));
        check("rd_div1",  bus1.read_value,     64'(m_rd[0]));
        check("irq_div1", irq1,                64'(m_irq[0]));
        check("rv_div4",  bus4.response_valid, 64'(m_rv[1]));
        check("rd_div4",  bus4.read_value,     64'(m_rd[1]));
        check("irq_div4", irq4,                64'(m_irq[1]));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b0, 1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b1, a, d);
    endtask

    initial begin
        logic [31:0] old_lo;
        bit          seen;

        // Reset and idle count.
        step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        check("reset_rv",  bus1.response_valid, 64'd0);
        check("reset_rd",  bus1.read_value,     64'd0);
        check("reset_irq", irq1,                64'd0);
        idle(10);
        rd(4'h0);
        check("idle10_read_div1", bus1.read_value, 64'd10);
        check("idle10_read_div4", bus4.read_value, 64'd2);

        // Interrupt rise at mtimecmp = 20, then fall after raising it.
        wr(4'hC, 32'd0);
        wr(4'h8, 32'd20);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            rd(4'h1);
            if (bus1.read_value == 32'd19) check("irq_before_20", irq1, 64'd0);
            if (bus1.read_value == 32'd20) begin
                check("irq_rise_at_20", irq1, 64'd1);
                seen = 1'b1;
            end
        end
        if (!seen) check("irq_rise_seen", 64'd0, 64'd1);
        idle(3);
        wr(4'h8, 32'd1000);
        check("irq_hold_at_write", irq1, 64'd1);
        idle(1);
        check("irq_fall", irq1, 64'd0);

        // 64-bit wrap against an all-ones comparator.
        wr(4'hC, 32'hFFFF_FFFF);
        wr(4'h8, 32'hFFFF_FFFF);
        wr(4'h4, 32'hFFFF_FFFF);
        wr(4'h0, 32'hFFFF_FFFE);
        idle(2);
        check("wrap_irq_high", irq1, 64'd1);
        rd(4'h0);
        check("wrap_lo", bus1.read_value, 64'd0);
        check("wrap_irq_low", irq1, 64'd0);
        rd(4'h4);
        check("wrap_hi", bus1.read_value, 64'd0);

        // Write on a tick cycle, back-to-back read/write/read.
        rd(4'h0);
        old_lo = m_mtime[0][31:0];
        wr(4'h3, 32'd5);
        check("wr_resp_old", bus1.read_value, 64'(old_lo));
        rd(4'h2);
        check("wr_then_read", bus1.read_value, 64'd5);

        // Reset the cycle after a read (request still high on the reset edge).
        wr(4'h8, 32'd1234);
        rd(4'h0);
        step(1'b1, 1'b1, 1'b0, 4'h0, 32'h0);
        check("reset_drops_rv", bus1.response_valid, 64'd0);
        idle(12);
        rd(4'h0);
        check("div4_12cyc", bus4.read_value, 64'd3);
        check("div1_12cyc", bus1.read_value, 64'd12);
        wr(4'h0, 32'd100);
        rd(4'h0);
        rd(4'h0);
        check("div4_hold_after_write", bus4.read_value, 64'd100);
        rd(4'h0);
        check("div4_next_tick", bus4.read_value, 64'd101);
        rd(4'h8);
        check("reset_cmp_lo", bus1.read_value, 64'hFFFF_FFFF);
        rd(4'hC);
        check("reset_cmp_hi", bus1.read_value, 64'hFFFF_FFFF);

        // Randomised traffic, biased towards small values so compares toggle.
        for (int k = 0; k < 1500; k++) begin
            logic        rs, rq, we;
            logic [3:0]  a;
            logic [31:0] wd;
            int          kind;
            rs   = ($urandom_range(0, 299) == 0);
            rq   = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            a    = 4'($urandom);
            kind = $urandom_range(0, 3);
            case (kind)
                0, 1:    wd = $urandom_range(0, 64);
                2:       wd = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0;
                default: wd = $urandom;
            endcase
            step(rs, rq, we, a, wd);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
